// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed single-precision neuron.
package neuron_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      OUT   = 2'd3
   } mac_state_t;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

   // Any value with the sign bit set (including -0 and negative NaN) clamps to +0.
   function automatic logic [31:0] fp_relu(input logic [31:0] v);
      return v[31] ? FP_POS_ZERO : v;
   endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Operand and result valid/ready streams of the sequential neuron.
interface neuron_mac_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic [31:0] in_w;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (output in_valid, in_x, in_w, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_x, in_w, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/ReLU.sv
// Rectifier on a single-precision value.
module ReLU
   import neuron_pkg::*;
(
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);
   assign y_o = fp_relu(x_i);
endmodule

// File: rtl/neuron_mac_seq_ctrl.sv
// Sequencer for the neuron MAC: FSM, beat counter, length clamp and handshake decode.
//   state | meaning
//   IDLE  | waiting for start; latches length
//   ACCUM | accepting operand pairs, one per cycle
//   FLUSH | folds the last product in, registers the activated result
//   OUT   | result held until downstream takes it
module neuron_mac_seq_ctrl
   import neuron_pkg::*;
#(
   parameter  int N_INPUTS = 64,
   localparam int CNT_W    = $clog2(N_INPUTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             in_valid_i,
   input  logic             out_ready_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic             busy_o,
   output logic             load_o,
   output logic             accept_o,
   output logic             flush_o
);
   mac_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, len_clamp;
   logic             out_valid_q, out_valid_d;

   assign len_clamp = (len_i > CNT_W'(N_INPUTS)) ? CNT_W'(N_INPUTS) : len_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (len_clamp == '0) ? FLUSH : ACCUM;
         ACCUM:   if (accept_o && (cnt_q + CNT_W'(1) == len_q)) state_d = FLUSH;
         FLUSH:   state_d = OUT;
         OUT:     if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q == ACCUM);
      busy_o      = (state_q != IDLE);
      load_o      = (state_q == IDLE) && start_i;
      accept_o    = in_ready_o && in_valid_i;
      flush_o     = (state_q == FLUSH);
      out_valid_o = out_valid_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      out_valid_d = out_valid_q;
      if (load_o) begin
         cnt_d = '0;
         len_d = len_clamp;
      end
      if (accept_o) cnt_d = cnt_q + CNT_W'(1);
      if (flush_o) out_valid_d = 1'b1;
      else if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
   end
endmodule

// File: rtl/spfp_adder_subtractor.sv
// Combinational IEEE-754 single add/subtract, round-to-nearest-even, subnormals flushed to zero.
module spfp_adder_subtractor
   import neuron_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] y_o
);
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++)
         if (v[i]) n = 5'(26 - i);
      return n;
   endfunction

   logic        sa, sb, sl, ss, swap, up, nan;
   logic [7:0]  ea, eb, el, d;
   logic [4:0]  sh, lz;
   logic [26:0] ml, ms, ms_al, norm;
   logic [53:0] al;
   logic [27:0] sum;
   logic [9:0]  e_n, e_f;
   logic [24:0] rnd;
   logic [22:0] mant;

   always_comb begin
      sa    = a_i[31];
      sb    = b_i[31] ^ sub_i;
      ea    = a_i[30:23];
      eb    = b_i[30:23];
      swap  = b_i[30:0] > a_i[30:0];
      sl    = swap ? sb : sa;
      ss    = swap ? sa : sb;
      el    = swap ? eb : ea;
      d     = swap ? (eb - ea) : (ea - eb);
      ml    = {1'b1, swap ? b_i[22:0] : a_i[22:0], 3'b000};
      ms    = {1'b1, swap ? a_i[22:0] : b_i[22:0], 3'b000};
      sh    = (d > 8'd27) ? 5'd27 : d[4:0];
      al    = {ms, 27'd0} >> sh;
      // Shifted-out bits collapse into a sticky bit so rounding still sees them.
      ms_al = al[53:27] | {26'd0, |al[26:0]};
      sum   = (sl == ss) ? ({1'b0, ml} + {1'b0, ms_al}) : ({1'b0, ml} - {1'b0, ms_al});
      lz    = lzc27(sum[26:0]);
      if (sum[27]) begin
         norm = {sum[27:2], |sum[1:0]};
         e_n  = {2'd0, el} + 10'd1;
      end else begin
         norm = sum[26:0] << lz;
         e_n  = {2'd0, el} - {5'd0, lz};
      end
      up   = norm[2] & ((|norm[1:0]) | norm[3]);
      rnd  = {1'b0, norm[26:3]} + {24'd0, up};
      e_f  = e_n + {9'd0, rnd[24]};
      mant = rnd[24] ? rnd[23:1] : rnd[22:0];
      nan  = (ea == 8'hFF && a_i[22:0] != 23'd0) || (eb == 8'hFF && b_i[22:0] != 23'd0) ||
             (ea == 8'hFF && eb == 8'hFF && sa != sb);

      if (sum == 28'd0)                y_o = FP_POS_ZERO;
      else if (e_f[9] || e_f == 10'd0) y_o = {sl, 31'd0};
      else if (e_f >= 10'd255)         y_o = {sl, 8'hFF, 23'd0};
      else                             y_o = {sl, e_f[7:0], mant};

      if (ea == 8'd0 && eb == 8'd0) y_o = {sa & sb, 31'd0};
      else if (ea == 8'd0)          y_o = {sb, b_i[30:0]};
      else if (eb == 8'd0)          y_o = a_i;

      if (nan)                 y_o = FP_QNAN;
      else if (ea == 8'hFF)    y_o = a_i;
      else if (eb == 8'hFF)    y_o = {sb, b_i[30:0]};
   end
endmodule

// File: rtl/spfp_multiplier.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
module spfp_multiplier
   import neuron_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);
   logic        s;
   logic [7:0]  ea, eb;
   logic [47:0] prod;
   logic [22:0] mn;
   logic        g, st;
   logic [9:0]  e, ef;
   logic [23:0] rnd;
   logic        nan;

   always_comb begin
      s    = a_i[31] ^ b_i[31];
      ea   = a_i[30:23];
      eb   = b_i[30:23];
      prod = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
      if (prod[47]) begin
         mn = prod[46:24];
         g  = prod[23];
         st = |prod[22:0];
      end else begin
         mn = prod[45:23];
         g  = prod[22];
         st = |prod[21:0];
      end
      e   = {2'd0, ea} + {2'd0, eb} - 10'd127 + {9'd0, prod[47]};
      rnd = {1'b0, mn} + {23'd0, g & (st | mn[0])};
      ef  = e + {9'd0, rnd[23]};
      nan = (ea == 8'hFF && a_i[22:0] != 23'd0) || (eb == 8'hFF && b_i[22:0] != 23'd0) ||
            (ea == 8'hFF && eb == 8'd0) || (eb == 8'hFF && ea == 8'd0);

      if (nan)                          p_o = FP_QNAN;
      else if (ea == 8'hFF || eb == 8'hFF) p_o = {s, 8'hFF, 23'd0};
      else if (ea == 8'd0 || eb == 8'd0)   p_o = {s, 31'd0};
      else if (ef[9] || ef == 10'd0)       p_o = {s, 31'd0};
      else if (ef >= 10'd255)              p_o = {s, 8'hFF, 23'd0};
      else                                 p_o = {s, ef[7:0], rnd[22:0]};
   end
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential single-precision neuron: act(bias + sum x[i]*w[i]) with one shared multiplier and adder.
module neuron_mac_seq
   import neuron_pkg::*;
#(
   parameter  int N_INPUTS = 64,
   localparam int CNT_W    = $clog2(N_INPUTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [31:0]      bias,
   input  logic             act_en,
   output logic             busy,
   neuron_mac_seq_if.slave  bus
);
   logic        load, accept, flush;
   logic [31:0] acc_q, acc_d, prod_q, prod_d, out_data_q, out_data_d;
   logic        prod_v_q, prod_v_d, act_en_q, act_en_d;
   logic [31:0] mul_p, add_b, add_s, relu_s;

   neuron_mac_seq_ctrl #(.N_INPUTS(N_INPUTS)) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .len_i       (len),
      .in_valid_i  (bus.in_valid),
      .out_ready_i (bus.out_ready),
      .in_ready_o  (bus.in_ready),
      .out_valid_o (bus.out_valid),
      .busy_o      (busy),
      .load_o      (load),
      .accept_o    (accept),
      .flush_o     (flush)
   );

   spfp_multiplier u_mul (.a_i(bus.in_x), .b_i(bus.in_w), .p_o(mul_p));

   // The single adder serves both accumulation and the final flush of the pending product.
   assign add_b = prod_v_q ? prod_q : FP_POS_ZERO;
   spfp_adder_subtractor u_add (.a_i(acc_q), .b_i(add_b), .sub_i(1'b0), .y_o(add_s));

   ReLU u_relu (.x_i(add_s), .y_o(relu_s));

   always_comb begin
      acc_d      = acc_q;
      act_en_d   = act_en_q;
      prod_d     = accept ? mul_p : prod_q;
      prod_v_d   = accept;
      out_data_d = out_data_q;
      if (load) begin
         acc_d    = bias;
         act_en_d = act_en;
      end else if (prod_v_q) begin
         acc_d = add_s;
      end
      if (flush) out_data_d = act_en_q ? relu_s : add_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         prod_q     <= '0;
         prod_v_q   <= 1'b0;
         act_en_q   <= 1'b0;
         out_data_q <= '0;
      end else begin
         acc_q      <= acc_d;
         prod_q     <= prod_d;
         prod_v_q   <= prod_v_d;
         act_en_q   <= act_en_d;
         out_data_q <= out_data_d;
      end
   end

   assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed scoreboard bench for neuron_mac_seq built with N_INPUTS = 8.
module tb_neuron_mac_seq;
   localparam int N  = 8;
   localparam int CW = $clog2(N + 1);
   localparam logic [31:0] ONE   = 32'h3F80_0000;
   localparam logic [31:0] TWO   = 32'h4000_0000;
   localparam logic [31:0] MONE  = 32'hBF80_0000;
   localparam logic [31:0] HALF  = 32'h3F00_0000;
   localparam logic [31:0] THREE = 32'h4040_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          act_en = 1'b0;
   logic          busy;
   logic [CW-1:0] len = '0;
   logic [31:0]   bias = '0;
   int            n_checks = 0;
   int            n_pass = 0;
   int            n_fail = 0;
   logic [31:0]   exp_q[$];

   neuron_mac_seq_if bus ();

   neuron_mac_seq #(.N_INPUTS(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .len    (len),
      .bias   (bias),
      .act_en (act_en),
      .busy   (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic expv);
      chk(tag, {31'd0, obs}, {31'd0, expv});
   endtask

   task automatic begin_neuron(input logic [CW-1:0] l, input logic [31:0] b,
                               input logic ae, input logic [31:0] expv);
      start  = 1'b1;
      len    = l;
      bias   = b;
      act_en = ae;
      exp_q.push_back(expv);
      tick();
      start = 1'b0;
   endtask

   task automatic stream(input int cycles, input logic [31:0] x, input logic [31:0] w,
                         output int acc);
      acc = 0;
      for (int i = 0; i < cycles; i++) begin
         bus.in_valid = 1'b1;
         bus.in_x     = x;
         bus.in_w     = w;
         if (bus.in_ready) acc++;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input string tag);
      int          k = 0;
      logic [31:0] expv;
      while (!bus.out_valid && k < 100) begin
         tick();
         k++;
      end
      chk_b({tag, "_valid"}, bus.out_valid, 1'b1);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_data"}, bus.out_data, expv);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk_b({tag, "_idle"}, bus.out_valid | busy, 1'b0);
   endtask

   initial begin
      int a;
      int total;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.out_ready = 1'b0;

      tick();
      tick();
      chk_b("rst_in_ready", bus.in_ready, 1'b0);
      chk_b("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, 32'h0);
      chk_b("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      // 4 x (1.0*2.0) with ReLU, latency of the result
      begin_neuron(CW'(4), 32'h0, 1'b1, 32'h4100_0000);
      chk_b("t1_in_ready", bus.in_ready, 1'b1);
      chk_b("t1_busy", busy, 1'b1);
      stream(4, ONE, TWO, a);
      chk("t1_accepts", 32'(a), 32'd4);
      chk_b("t1_flush_no_valid", bus.out_valid, 1'b0);
      tick();
      chk_b("t1_valid_e1", bus.out_valid, 1'b1);
      collect("t1");

      // negative sum, identity then ReLU
      begin_neuron(CW'(2), 32'h0, 1'b0, 32'hC000_0000);
      stream(2, ONE, MONE, a);
      chk("t2a_accepts", 32'(a), 32'd2);
      collect("t2a");
      begin_neuron(CW'(2), 32'h0, 1'b1, 32'h0000_0000);
      stream(2, ONE, MONE, a);
      collect("t2b");

      // zero-length neuron: bias only, in_ready never raised
      bus.in_valid = 1'b1;
      bus.in_x     = ONE;
      bus.in_w     = ONE;
      chk_b("t3_idle_no_ready", bus.in_ready, 1'b0);
      begin_neuron(CW'(0), HALF, 1'b1, HALF);
      chk_b("t3_flush_no_ready", bus.in_ready, 1'b0);
      chk_b("t3_flush_no_valid", bus.out_valid, 1'b0);
      tick();
      chk_b("t3_out_no_ready", bus.in_ready, 1'b0);
      chk_b("t3_valid_2nd_edge", bus.out_valid, 1'b1);
      bus.in_valid = 1'b0;
      collect("t3");

      // gapped input, backpressure, start ignored during OUT and on the transfer edge
      begin_neuron(CW'(3), ONE, 1'b0, 32'h4080_0000);
      total = 0;
      for (int i = 0; i < 3; i++) begin
         stream(1, ONE, ONE, a);
         total += a;
         repeat (2) tick();
      end
      chk("t4_accepts", 32'(total), 32'd3);
      len = CW'(1);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         chk_b("t4_hold_valid", bus.out_valid, 1'b1);
         chk("t4_hold_data", bus.out_data, 32'h4080_0000);
         tick();
      end
      start = 1'b1;
      bus.out_ready = 1'b1;
      chk("t4_data", bus.out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
      tick();
      start = 1'b0;
      bus.out_ready = 1'b0;
      chk_b("t4_start_on_xfer_ignored", busy, 1'b0);
      chk_b("t4_valid_dropped", bus.out_valid, 1'b0);

      // reset mid-run, then a clean run
      begin_neuron(CW'(4), 32'h0, 1'b0, 32'h0);
      void'(exp_q.pop_back());
      stream(2, ONE, TWO, a);
      rst = 1'b1;
      #1;
      chk_b("t5_rst_busy", busy, 1'b0);
      chk_b("t5_rst_in_ready", bus.in_ready, 1'b0);
      chk_b("t5_rst_out_valid", bus.out_valid, 1'b0);
      chk("t5_rst_out_data", bus.out_data, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      begin_neuron(CW'(1), 32'h0, 1'b0, THREE);
      stream(1, THREE, ONE, a);
      chk("t5_accepts", 32'(a), 32'd1);
      collect("t5");

      // len above N_INPUTS clamps to exactly N beats
      begin_neuron(CW'(13), 32'h0, 1'b0, 32'h4100_0000);
      stream(13, ONE, ONE, a);
      chk("t6_accepts", 32'(a), 32'd8);
      collect("t6");

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Time-multiplexed single-precision neuron: it computes `act(bias + Σ x[i]·w[i])` over a runtime-selectable number of inputs. It uses one shared `spfp_multiplier` and one shared `spfp_adder_subtractor`, not one multiplier and one adder per input. Operands arrive as a valid/ready stream, and the activated result leaves on a second valid/ready port. The block is the area-scalable successor to the fully parallel 8/16/32/64-input neuron MACs, and is intended as the per-neuron engine of sequential layer controllers.

## Interface
Parameters:
- `N_INPUTS`, 64: maximum inputs per neuron. Must be ≥ 1.
- `CNT_W`, `$clog2(N_INPUTS+1)`: width of the length and count fields. This is a derived localparam.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begins a neuron computation. Sampled only in IDLE.
- `len`  in  CNT_W  number of input beats. Latched on start.
- `bias`  in  32  IEEE-754 single bias. Latched on start as the accumulator seed.
- `act_en`  in  1  1 selects ReLU on the result, 0 selects identity. Latched on start.
- `in_valid`  in  1  an operand pair is present.
- `in_ready`  out  1  the block accepts a pair this cycle.
- `in_x`  in  32  input activation (single).
- `in_w`  in  32  weight (single).
- `out_valid`  out  1  the result is held on `out_data`.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  activated result (single).
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ACCUM, FLUSH and OUT.
- IDLE:
  - `start` latches `bias` into `acc`, latches `act_en`, clears `cnt` and clears `prod_v`.
  - The latched length is `min(len, N_INPUTS)`.
  - If the latched length is 0, go to FLUSH. Otherwise go to ACCUM.
- ACCUM:
  - `in_ready` = 1.
  - Accept occurs when `in_valid && in_ready`. On accept: `prod_q <= in_x*in_w`, `prod_v <= 1`, `cnt <= cnt+1`. With no accept: `prod_v <= 0`.
  - Every cycle, if `prod_v` is set, then `acc <= acc + prod_q`. This is a two-stage pipeline, so a new pair is accepted every cycle with no stall.
  - The accept that makes `cnt` equal the latched length moves the FSM to FLUSH.
  - Gaps in `in_valid` are legal and do not change the result.
- FLUSH, one cycle:
  - `out_data <= act(acc + (prod_v ? prod_q : +0))`.
  - `out_valid <= 1`.
  - Go to OUT.
- OUT:
  - `in_ready` = 0.
  - `out_data` and `out_valid` are held stable until `out_valid && out_ready`.
  - On that transfer edge, `out_valid <= 0` and the FSM returns to IDLE.
- Activation `act`:
  - With `act_en` = 1, any value with sign bit set (including −0 and negative NaN) becomes `32'h0000_0000`. All other values pass unchanged.
  - With `act_en` = 0, the value passes unchanged.
- Summation order is sequential (bias, then index 0 upward). Rounding is whatever the shared adder produces.
- Boundary conditions:
  - `start` in any non-IDLE state is ignored.
  - `in_valid` outside ACCUM is ignored.
  - `start` on the same edge as an OUT transfer is ignored, because the FSM is not yet in IDLE.
  - `len` > `N_INPUTS` is clamped. Exactly `N_INPUTS` beats are accepted.
  - A reset asserted mid-operation aborts the computation immediately. No partial result is emitted.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0. Internally, state=IDLE and `acc`, `prod_q`, `prod_v`, `cnt` are 0.
- `in_ready` and `busy` are combinational decodes of the state register.
- Latency, with the last beat accepted on edge E:
  - FLUSH occupies cycle E→E+1.
  - `out_valid` is high from edge E+1.
- Throughput: one beat per cycle.
  - Without backpressure, a back-to-back neuron takes L+3 cycles: start, L beats, FLUSH, OUT with `out_ready` high.
  - With `len`=0, `out_valid` rises on the second edge after `start` is sampled.
- Critical path: multiplier (or adder) plus register. The multiplier and adder never chain combinationally, except in FLUSH, where the chain is adder then ReLU.

## Structure
- Shared package `neuron_pkg` holds:
  - the state enum `mac_state_t` (IDLE, ACCUM, FLUSH, OUT);
  - `FP_POS_ZERO` = `32'h0000_0000`;
  - the function `fp_relu(logic [31:0])`.
- Existing `spfp_multiplier`, `spfp_adder_subtractor` (add mode) and `ReLU` are instantiated once each.
- One natural sub-module is `neuron_mac_seq_ctrl`. It contains the FSM, `cnt`, the length clamp and the handshake decode, and drives enables to the datapath.

## Test plan
- `len`=4, `bias`=0, x=1.0 (3F800000), w=2.0 (40000000) with continuous `in_valid`, `act_en`=1 → `out_data`=41000000 (8.0). `out_valid` rises exactly 1 edge after the 4th accept.
- `len`=2, `bias`=0, x=1.0, w=−1.0 (BF800000): with `act_en`=0 → C0000000 (−2.0); with `act_en`=1 → 00000000.
- `len`=0, `bias`=3F000000 (0.5) → `out_data`=3F000000. No `in_ready` pulse occurs.
- `len`=3, `bias`=3F800000, x=w=1.0, `in_valid` gaps of 2 cycles between beats, `out_ready` held low 5 cycles → `out_data`=40800000 (4.0), stable while `out_valid` is held. A `start` pulse during OUT is ignored.
- Reset asserted after 2 of 4 beats → all outputs reset at once. Then a new `len`=1 run with x=3.0 (40400000), w=1.0, `bias`=0 → 40400000, with no residue from the aborted run.
- `N_INPUTS`=8, `len`=13, x=w=1.0, `bias`=0 → exactly 8 accepts and `out_data`=41000000.
